// File: rtl/moore_pattern_counter.sv
// moore_pattern_counter
//   Overlapping Moore sequence detector. Serial input is sampled on an
//   internal clock-enable tick. Detections are counted in a DIGITS-digit BCD
//   counter, which is shown on a scanned, active-low seven-segment display.
//   The KMP-style fallback table is built at elaboration from PATTERN.
//   Optional build macro: MOORE_LEADING_BLANK_EN blanks the leading zero
//   digits above the most significant nonzero digit. Digit 0 is always shown.
//   o_dbg_state exposes the FSM state (k = leading pattern bits matched).
//   This block has no valid/ready handshakes.
module moore_pattern_counter #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1101,
  parameter int                     DIGITS      = 2,
  parameter int                     DIV         = 25000000,
  parameter int                     SCAN_DIV    = 50000,
  localparam int                    SW          = $clog2(PATTERN_LEN + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in,
  output logic                match,
  output logic [4*DIGITS-1:0] count_bcd,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic [SW-1:0]       o_dbg_state
);

  localparam int DW  = (DIV > 1)      ? $clog2(DIV)      : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  // Next state from Sk on input bit b. This is the longest prefix of PATTERN
  // that is a suffix of the k matched bits followed by b. Lengths up to
  // PATTERN_LEN are allowed, so a fully self-overlapping pattern can stay in
  // S(PATTERN_LEN).
  function automatic logic [SW-1:0] f_next(input int k, input logic b);
    logic [SW-1:0] res;
    logic          ok;
    logic          sb;
    int            j;
    res = '0;
    for (int l = 1; l <= PATTERN_LEN; l++) begin
      if (l <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < PATTERN_LEN; i++) begin
          if (i < l) begin
            j = k + 1 - l + i;
            if (j == k) sb = b;
            else        sb = PATTERN[PATTERN_LEN-1-j];
            if (sb != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
          end
        end
        if (ok) res = SW'(l);
      end
    end
    return res;
  endfunction

  logic [SW-1:0]       r_state;
  logic [SW-1:0]       w_state_nxt;
  logic [DW-1:0]       r_div;
  logic                w_tick;
  logic [4*DIGITS-1:0] r_count;
  logic [4*DIGITS-1:0] w_count_inc;
  logic                w_carry;
  logic [SCW-1:0]      r_scan;
  logic                w_scan_wrap;
  logic [IW-1:0]       r_idx;
  logic [3:0]          w_digit;
  logic [SW-1:0]       w_nxt0 [0:PATTERN_LEN];
  logic [SW-1:0]       w_nxt1 [0:PATTERN_LEN];
`ifdef MOORE_LEADING_BLANK_EN
  logic                w_blank;
  logic                w_upper_zero;
`endif

  // Transition table, one constant entry per state and input value
  for (genvar g = 0; g <= PATTERN_LEN; g++) begin : g_tbl
    localparam logic [SW-1:0] L_NXT0 = f_next(g, 1'b0);
    localparam logic [SW-1:0] L_NXT1 = f_next(g, 1'b1);
    assign w_nxt0[g] = L_NXT0;
    assign w_nxt1[g] = L_NXT1;
  end

  // Sample-tick divider: tick is high on the last count of each period
  assign w_tick = (r_div == DW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset)       r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + 1'b1;
  end

  // FSM state register, advances only on tick clocks
  always_ff @(posedge clock) begin
    if (reset)       r_state <= '0;
    else if (w_tick) r_state <= w_state_nxt;
  end

  // FSM next state: table lookup; unreachable encodings recover to S0
  always_comb begin
    w_state_nxt = '0;
    for (int k = 0; k <= PATTERN_LEN; k++) begin
      if (r_state == SW'(k)) w_state_nxt = in ? w_nxt1[k] : w_nxt0[k];
    end
  end

  // FSM outputs: Moore decode of the registered state
  always_comb begin
    match       = (r_state == SW'(PATTERN_LEN));
    o_dbg_state = r_state;
  end

  // BCD increment with ripple carry; all-nines wraps to all-zeros
  always_comb begin
    w_count_inc = r_count;
    w_carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_count[4*d +: 4] == 4'd9) begin
          w_count_inc[4*d +: 4] = 4'd0;
        end else begin
          w_count_inc[4*d +: 4] = r_count[4*d +: 4] + 4'd1;
          w_carry               = 1'b0;
        end
      end
    end
  end

  // Detection counter: bump on each tick that enters S(PATTERN_LEN)
  always_ff @(posedge clock) begin
    if (reset)
      r_count <= '0;
    else if (w_tick && (w_state_nxt == SW'(PATTERN_LEN)))
      r_count <= w_count_inc;
  end

  assign count_bcd = r_count;

  // Display scan timer, free-running on every clock
  assign w_scan_wrap = (r_scan == SCW'(SCAN_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset)            r_scan <= '0;
    else if (w_scan_wrap) r_scan <= '0;
    else                  r_scan <= r_scan + 1'b1;
  end

  // Scanned digit index, steps 0..DIGITS-1 on each scan wrap
  always_ff @(posedge clock) begin
    if (reset)
      r_idx <= '0;
    else if (w_scan_wrap)
      r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
  end

  // Digit select and digit mux. The scan runs from the top digit down so the
  // leading-zero test covers the selected digit and every digit above it.
  always_comb begin
    w_digit = 4'd0;
    an      = '1;
`ifdef MOORE_LEADING_BLANK_EN
    w_blank      = 1'b0;
    w_upper_zero = 1'b1;
`endif
    for (int d = DIGITS - 1; d >= 0; d--) begin
`ifdef MOORE_LEADING_BLANK_EN
      if (r_count[4*d +: 4] != 4'd0) w_upper_zero = 1'b0;
`endif
      if (r_idx == IW'(d)) begin
        w_digit = r_count[4*d +: 4];
        an[d]   = 1'b0;
`ifdef MOORE_LEADING_BLANK_EN
        w_blank = (d != 0) && w_upper_zero;
`endif
      end
    end
  end

  // Seven-segment decode {g,f,e,d,c,b,a}, active-low; non-BCD shows blank
  always_comb begin
    case (w_digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
`ifdef MOORE_LEADING_BLANK_EN
    if (w_blank) seg = 7'b1111111;
`endif
  end

endmodule
